div8_restoring: RTL and testbench

Sequential unsigned divider: one WIDTH-bit dividend and divisor per transaction, returning quotient and remainder after WIDTH iteration cycles. Sits directly downstream of the borrow-in subtractor stage: it instantiates that stage once, drives it with the partial remainder and divisor (borrow-in tied 0), and consumes its difference each cycle. Valid/ready handshakes on both sides let it drop between a register-file read port and a writeback stage.

---
 rtl/div8_restoring.sv | 168 ++++++++++++++++
 tb/tb_div8_restoring.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div8_restoring.sv
// Sequential restoring unsigned divider: one quotient bit per cycle, using a
// borrow-in subtractor stage to form the trial difference of each iteration.

module div8_sub_stage #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   // borrow_out set means a < b + borrow_in
   assign {borrow_out, diff} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, borrow_in};

endmodule

module div8_restoring #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             VALID_IN,
   output logic             READY_IN,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   output logic             VALID_OUT,
   input  logic             READY_OUT,
   output logic [WIDTH-1:0] QUOTIENT,
   output logic [WIDTH-1:0] REMAINDER,
   output logic             DIV0
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic             accept_s;
   logic             last_s;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] divisor_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic             div0_r;
   logic             valid_out_r;
   logic             ready_in_r;
   logic [WIDTH:0]   t_s;
   logic [WIDTH-1:0] diff_s;
   logic             borrow_s;
   logic             ge_s;
   logic [WIDTH-1:0] r_next_s;
   logic [WIDTH-1:0] q_next_s;

   assign t_s = {r_r, q_r[WIDTH-1]};

   div8_sub_stage #(.WIDTH(WIDTH)) u_sub (
      .a          (t_s[WIDTH-1:0]),
      .b          (divisor_r),
      .borrow_in  (1'b0),
      .diff       (diff_s),
      .borrow_out (borrow_s)
   );

   // A carry out of the shifted remainder always dominates the divisor
   assign ge_s     = t_s[WIDTH] | ~borrow_s;
   assign r_next_s = ge_s ? diff_s : t_s[WIDTH-1:0];
   assign q_next_s = {q_r[WIDTH-2:0], ge_s};

   // Next-state decode and transaction events
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      last_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (VALID_IN) begin
               accept_s     = 1'b1;
               state_next_s = (DIVISOR == {WIDTH{1'b0}}) ? ST_DONE : ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (count_r == LAST) begin
               last_s       = 1'b1;
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (READY_OUT) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Iteration datapath, result registers and registered handshake outputs
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         count_r     <= {CW{1'b0}};
         divisor_r   <= {WIDTH{1'b0}};
         q_r         <= {WIDTH{1'b0}};
         r_r         <= {WIDTH{1'b0}};
         quotient_r  <= {WIDTH{1'b0}};
         remainder_r <= {WIDTH{1'b0}};
         div0_r      <= 1'b0;
         valid_out_r <= 1'b0;
         ready_in_r  <= 1'b1;
      end else begin
         valid_out_r <= (state_next_s == ST_DONE);
         ready_in_r  <= (state_next_s == ST_IDLE);
         if (accept_s) begin
            divisor_r <= DIVISOR;
            q_r       <= DIVIDEND;
            r_r       <= {WIDTH{1'b0}};
            count_r   <= {CW{1'b0}};
            if (DIVISOR == {WIDTH{1'b0}}) begin
               quotient_r  <= {WIDTH{1'b1}};
               remainder_r <= DIVIDEND;
               div0_r      <= 1'b1;
            end else begin
               div0_r      <= 1'b0;
            end
         end else if (state_r == ST_RUN) begin
            q_r     <= q_next_s;
            r_r     <= r_next_s;
            count_r <= count_r + CW'(1);
            if (last_s) begin
               quotient_r  <= q_next_s;
               remainder_r <= r_next_s;
            end
         end
      end
   end

   assign READY_IN  = ready_in_r;
   assign VALID_OUT = valid_out_r;
   assign QUOTIENT  = quotient_r;
   assign REMAINDER = remainder_r;
   assign DIV0      = div0_r;

endmodule

// File: tb/tb_div8_restoring.sv
// Directed and randomized checks of div8_restoring against an arithmetic
// reference model (native / and %).

module tb_div8_restoring;

   logic       CLK = 1'b0;
   logic       RESETN;
   logic       VALID_IN;
   logic       READY_IN;
   logic [7:0] DIVIDEND;
   logic [7:0] DIVISOR;
   logic       VALID_OUT;
   logic       READY_OUT;
   logic [7:0] QUOTIENT;
   logic [7:0] REMAINDER;
   logic       DIV0;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   div8_restoring #(.WIDTH(8)) dut (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .VALID_IN  (VALID_IN),
      .READY_IN  (READY_IN),
      .DIVIDEND  (DIVIDEND),
      .DIVISOR   (DIVISOR),
      .VALID_OUT (VALID_OUT),
      .READY_OUT (READY_OUT),
      .QUOTIENT  (QUOTIENT),
      .REMAINDER (REMAINDER),
      .DIV0      (DIV0)
   );

   function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] d);
      if (d == 8'd0) return 8'hFF;
      return a / d;
   endfunction

   function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] d);
      if (d == 8'd0) return a;
      return a % d;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one operation from IDLE; return edges from accept to VALID_OUT.
   task automatic run_op(input logic [7:0] a, input logic [7:0] d,
                         output int lat, output logic rdy_seen);
      @(negedge CLK);
      DIVIDEND = a;
      DIVISOR  = d;
      VALID_IN = 1'b1;
      @(negedge CLK);
      VALID_IN = 1'b0;
      DIVIDEND = 8'($urandom);
      DIVISOR  = 8'($urandom);
      lat      = 0;
      rdy_seen = 1'b0;
      while (VALID_OUT !== 1'b1 && lat < 40) begin
         rdy_seen = rdy_seen | READY_IN;
         @(negedge CLK);
         lat++;
      end
      rdy_seen = rdy_seen | READY_IN;
   endtask

   task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] d,
                               input int lat, input logic rdy_seen);
      check({tag, "_lat"}, 32'(lat), (d == 8'd0) ? 32'd0 : 32'd8);
      check({tag, "_q"}, {24'd0, QUOTIENT}, {24'd0, ref_q(a, d)});
      check({tag, "_r"}, {24'd0, REMAINDER}, {24'd0, ref_r(a, d)});
      check({tag, "_div0"}, {31'd0, DIV0}, {31'd0, (d == 8'd0)});
      check({tag, "_busy"}, {31'd0, rdy_seen}, 32'd0);
   endtask

   // With READY_OUT high the result is taken on the next edge.
   task automatic drain(input string tag);
      @(negedge CLK);
      check({tag, "_vout_low"}, {31'd0, VALID_OUT}, 32'd0);
      check({tag, "_rdy_high"}, {31'd0, READY_IN}, 32'd1);
   endtask

   initial begin
      int         lat;
      logic       rdy;
      logic       vseen;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] ca [6] = '{8'd255, 8'd5, 8'd255, 8'd0, 8'd128, 8'd200};
      logic [7:0] cd [6] = '{8'd1, 8'd9, 8'd255, 8'd13, 8'd128, 8'd7};

      RESETN    = 1'b0;
      VALID_IN  = 1'b0;
      READY_OUT = 1'b1;
      DIVIDEND  = 8'd0;
      DIVISOR   = 8'd0;
      repeat (3) @(negedge CLK);
      RESETN = 1'b1;
      @(negedge CLK);
      check("reset_rdy", {31'd0, READY_IN}, 32'd1);
      check("reset_vout", {31'd0, VALID_OUT}, 32'd0);
      check("reset_q", {24'd0, QUOTIENT}, 32'd0);
      check("reset_r", {24'd0, REMAINDER}, 32'd0);
      check("reset_div0", {31'd0, DIV0}, 32'd0);

      // Directed corners including 200/7
      for (int i = 0; i < 6; i++) begin
         run_op(ca[i], cd[i], lat, rdy);
         check_result($sformatf("corner%0d", i), ca[i], cd[i], lat, rdy);
         drain($sformatf("corner%0d", i));
      end

      // Zero divisor followed by a normal operation
      run_op(8'd77, 8'd0, lat, rdy);
      check_result("div0", 8'd77, 8'd0, lat, rdy);
      drain("div0");
      run_op(8'd100, 8'd10, lat, rdy);
      check_result("after_div0", 8'd100, 8'd10, lat, rdy);
      drain("after_div0");

      // Backpressure with ignored VALID_IN pulses
      READY_OUT = 1'b0;
      run_op(8'd100, 8'd3, lat, rdy);
      check_result("bp", 8'd100, 8'd3, lat, rdy);
      for (int i = 0; i < 5; i++) begin
         VALID_IN = i[0];
         DIVIDEND = 8'd9;
         DIVISOR  = 8'd0;
         @(negedge CLK);
         check("bp_hold_q", {24'd0, QUOTIENT}, 32'd33);
         check("bp_hold_r", {24'd0, REMAINDER}, 32'd1);
         check("bp_hold_v", {31'd0, VALID_OUT}, 32'd1);
         check("bp_hold_rdy", {31'd0, READY_IN}, 32'd0);
      end
      VALID_IN  = 1'b0;
      READY_OUT = 1'b1;
      drain("bp");
      check("bp_keep_q", {24'd0, QUOTIENT}, 32'd33);

      // Reset in the middle of an operation
      @(negedge CLK);
      DIVIDEND = 8'd250;
      DIVISOR  = 8'd6;
      VALID_IN = 1'b1;
      @(negedge CLK);
      VALID_IN = 1'b0;
      repeat (4) @(negedge CLK);
      RESETN = 1'b0;
      #1;
      check("midrst_vout", {31'd0, VALID_OUT}, 32'd0);
      check("midrst_rdy", {31'd0, READY_IN}, 32'd1);
      check("midrst_q", {24'd0, QUOTIENT}, 32'd0);
      @(negedge CLK);
      RESETN = 1'b1;
      vseen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         vseen = vseen | VALID_OUT;
      end
      check("midrst_no_result", {31'd0, vseen}, 32'd0);
      run_op(8'd250, 8'd6, lat, rdy);
      check_result("after_rst", 8'd250, 8'd6, lat, rdy);
      drain("after_rst");

      // Random sweep against the reference model and the division invariant
      for (int i = 0; i < 300; i++) begin
         a = 8'($urandom);
         d = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         run_op(a, d, lat, rdy);
         check_result($sformatf("rnd%0d", i), a, d, lat, rdy);
         if (d != 8'd0) begin
            check($sformatf("rnd%0d_inv", i),
                  {31'd0, ((32'(QUOTIENT) * 32'(d) + 32'(REMAINDER)) == 32'(a)) && (REMAINDER < d)},
                  32'd1);
         end
         drain($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
